// File: rtl/seq_shift_add_multiplier_pkg.sv
// seq_shift_add_multiplier_pkg: shared state encodings and default width for the multiplier
package seq_shift_add_multiplier_pkg;
  localparam int WIDTH_DEF = 32;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/seq_shift_add_multiplier_if.sv
// seq_shift_add_multiplier_if: operand/product handshake bundle for the multiplier
interface seq_shift_add_multiplier_if #(parameter int WIDTH = 32);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in1;
  logic [WIDTH-1:0]   in2;
  logic               is_signed;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] product;
  modport master (
    output in_valid, in1, in2, is_signed, out_ready,
    input  in_ready, out_valid, product
  );
  modport slave (
    input  in_valid, in1, in2, is_signed, out_ready,
    output in_ready, out_valid, product
  );
endinterface

// File: rtl/seq_shift_add_multiplier_rca.sv
// RippleCarryAdder_32bit: 32-bit ripple carry adder with carry in/out
module RippleCarryAdder_32bit (
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  input  logic        c_in,
  output logic [31:0] sum,
  output logic        c_out
);
  logic [32:0] c;
  assign c[0]  = c_in;
  assign c_out = c[32];
  for (genvar i = 0; i < 32; i++) begin : g_fa
    assign sum[i]   = in1[i] ^ in2[i] ^ c[i];
    assign c[i+1]   = (in1[i] & in2[i]) | (c[i] & (in1[i] ^ in2[i]));
  end
endmodule

// File: rtl/seq_shift_add_multiplier.sv
// seq_shift_add_multiplier: multi-cycle shift-and-add multiplier, one RCA step per clock
module seq_shift_add_multiplier
  import seq_shift_add_multiplier_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input logic clk,
  input logic rst,
  seq_shift_add_multiplier_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  state_t               state, state_nxt;
  logic [WIDTH-1:0]     a, q, m, sum;
  logic [CW-1:0]        cnt;
  logic                 neg, c_out, last;
  logic [2*WIDTH-1:0]   step, product;
  logic [WIDTH-1:0]     m_abs, q_abs;
  RippleCarryAdder_32bit u_rca (
    .in1  (a),
    .in2  (m),
    .c_in (1'b0),
    .sum  (sum),
    .c_out(c_out)
  );
  assign step  = q[0] ? {c_out, sum, q[WIDTH-1:1]} : {1'b0, a, q[WIDTH-1:1]};
  assign last  = (state == S_RUN) && (cnt == CW'(WIDTH - 1));
  assign m_abs = (bus.is_signed && bus.in1[WIDTH-1]) ? -bus.in1 : bus.in1;
  assign q_abs = (bus.is_signed && bus.in2[WIDTH-1]) ? -bus.in2 : bus.in2;
  assign bus.product = product;
  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end
  // next-state: accept in IDLE, WIDTH steps in RUN, wait for consumer in DONE
  always_comb begin
    state_nxt = state == S_IDLE ? (bus.in_valid ? S_RUN : S_IDLE) :
                state == S_RUN  ? (last ? S_DONE : S_RUN) :
                state == S_DONE ? (bus.out_ready ? S_IDLE : S_DONE) : S_IDLE;
  end
  // handshake outputs decoded from state
  always_comb begin
    bus.in_ready  = state == S_IDLE;
    bus.out_valid = state == S_DONE;
  end
  // datapath: latch magnitudes on accept, shift-add while running, sign-fix on last step
  always_ff @(posedge clk) begin
    if (rst) begin
      a       <= '0;
      q       <= '0;
      m       <= '0;
      cnt     <= '0;
      neg     <= 1'b0;
      product <= '0;
    end else if (state == S_IDLE && bus.in_valid) begin
      m   <= m_abs;
      q   <= q_abs;
      neg <= bus.is_signed & (bus.in1[WIDTH-1] ^ bus.in2[WIDTH-1]);
      a   <= '0;
      cnt <= '0;
    end else if (state == S_RUN) begin
      {a, q} <= step;
      cnt    <= cnt + 1'b1;
      if (last) product <= neg ? -step : step;
    end
  end
endmodule
